control_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute/writeback controller for the 32-bit instruction datapath.
- Owns the program counter (PC).
- Fetches from instruction memory over a req/ack handshake.
- Pulses the instruction decoder's enable, starts the ALU, and issues the register-file write strobe.
- Handles the HALT and JUMP opcodes itself; no ALU cycle is spent on either.

---
 rtl/control_sequencer.sv | 155 +++++++++++++++
 tb/tb_control_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_sequencer: fetch/decode/execute/writeback controller owning PC.  |
// | Optional single-step: define CONTROL_SEQUENCER_SINGLE_STEP_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module control_sequencer #(
  parameter int         ADDR_WIDTH  = 8,
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter logic [3:0] JUMP_OPCODE = 4'hE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  clear,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_data,
  output logic [31:0]           instruction,
  output logic                  decode_enable,
  input  logic [3:0]            opcode,
  input  logic [7:0]            jump_target,
  output logic                  alu_start,
  input  logic                  alu_done,
  output logic                  reg_write_enable,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_ALU_WAIT  = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] w_jump_addr;
  logic                  w_continue;

  generate
    if (ADDR_WIDTH > 8) begin : g_jt_zext
      assign w_jump_addr = {{(ADDR_WIDTH-8){1'b0}}, jump_target};
    end else if (ADDR_WIDTH == 8) begin : g_jt_same
      assign w_jump_addr = jump_target;
    end else begin : g_jt_trunc
      assign w_jump_addr = jump_target[ADDR_WIDTH-1:0];
    end
  endgenerate

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  // Set when the current instruction was launched by a step pulse.
  logic step_q, step_d;

  always_ff @(posedge clock) begin
    if (!reset_n) step_q <= 1'b0;
    else          step_q <= step_d;
  end

  assign w_continue = run && !step_q;
`else
  assign w_continue = run;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    alu_start = 1'b0;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    step_d    = step_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        if (step) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end else if (run) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
        end
`else
        if (run) state_d = S_FETCH;
`endif
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        // HALT and JUMP are resolved here without an ALU cycle.
        if (opcode == HALT_OPCODE) begin
          state_d = S_HALTED;
        end else if (opcode == JUMP_OPCODE) begin
          pc_d    = w_jump_addr;
          state_d = w_continue ? S_FETCH : S_IDLE;
        end else begin
          alu_start = 1'b1;
          state_d   = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (alu_done) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = w_continue ? S_FETCH : S_IDLE;
      end
      S_HALTED: begin
        if (clear) begin
          pc_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req         = (state_q == S_FETCH);
  assign imem_addr        = pc_q;
  assign instruction      = instr_q;
  assign decode_enable    = (state_q == S_DECODE);
  assign reg_write_enable = (state_q == S_WRITEBACK);
  assign pc               = pc_q;
  assign halted           = (state_q == S_HALTED);
  assign busy             = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_control_sequencer: directed bench with instruction-memory, decoder and|
// | ALU models; strobe events are matched against an expected-event queue.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_control_sequencer;

  localparam logic [7:0] EV_FETCH = 8'd1;
  localparam logic [7:0] EV_DEC   = 8'd2;
  localparam logic [7:0] EV_ALU   = 8'd3;
  localparam logic [7:0] EV_WB    = 8'd4;

  typedef struct {
    logic [7:0]  kind;
    int          cyc;
    logic [15:0] val;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0, run = 1'b0, clear = 1'b0;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic        imem_req, decode_enable, alu_start, reg_write_enable, busy, halted;
  logic [7:0]  imem_addr, pc;
  logic        imem_ack = 1'b0, alu_done = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] instruction;
  logic [3:0]  opcode = 4'h0;
  logic [7:0]  jump_target = 8'h0;

  logic [31:0] mem [256];
  ev_t         sbq [$];
  int          cyc = 0, checks = 0, errors = 0;
  int          imem_lat = 0, alu_lat = 1, fcnt = 0, alu_cnt = 0, t0 = 0;
  logic        dec_seen = 1'b0, req_prev = 1'b0;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .run(run), .clear(clear),
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instruction(instruction),
    .decode_enable(decode_enable), .opcode(opcode), .jump_target(jump_target),
    .alu_start(alu_start), .alu_done(alu_done),
    .reg_write_enable(reg_write_enable), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic exp_evt(input logic [7:0] kind, input int c, input logic [15:0] val);
    sbq.push_back('{kind, c, val});
  endtask

  task automatic check_evt(input logic [7:0] kind, input logic [15:0] val);
    ev_t e;
    if (sbq.size() == 0) begin
      chk("unexpected_evt", {8'h0, kind, 32'(cyc), val}, 64'h0);
    end else begin
      e = sbq.pop_front();
      chk("event", {8'h0, kind, 32'(cyc), val}, {8'h0, e.kind, 32'(e.cyc), e.val});
    end
  endtask

  // One clock: advance, update environment models, record strobe events.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (dec_seen) begin
      opcode      = instruction[31:28];
      jump_target = instruction[7:0];
    end
    #1;
    dec_seen = decode_enable;
    if (imem_req && !req_prev) check_evt(EV_FETCH, {8'h0, imem_addr});
    req_prev = imem_req;
    if (decode_enable)    check_evt(EV_DEC, 16'h0);
    if (alu_start)        check_evt(EV_ALU, 16'h0);
    if (reg_write_enable) check_evt(EV_WB, {8'h0, pc});
    chk("strobe_excl", 64'((decode_enable & alu_start) | (decode_enable & reg_write_enable)
                           | (alu_start & reg_write_enable)), 64'h0);
    imem_ack = 1'b0;
    if (imem_req) begin
      if (fcnt == imem_lat) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        fcnt      = 0;
      end else begin
        fcnt++;
      end
    end else begin
      fcnt = 0;
    end
    if (alu_cnt > 0) begin
      alu_cnt--;
      alu_done = (alu_cnt == 0);
    end else begin
      alu_done = 1'b0;
    end
    if (alu_start) alu_cnt = alu_lat;
  endtask

  task automatic do_reset();
    chk("sb_empty", 64'(sbq.size()), 64'h0);
    sbq.delete();
    reset_n = 1'b0;
    run     = 1'b0;
    clear   = 1'b0;
    repeat (2) tick();
    alu_cnt  = 0;
    alu_done = 1'b0;
    reset_n  = 1'b1;
    t0       = cyc;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;

    // Reset state, then one ALU instruction with minimum latencies.
    mem[0] = 32'h1000_0000;
    imem_lat = 0; alu_lat = 1;
    do_reset();
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_instr", 64'(instruction), 64'h0);
    chk("rst_flags", 64'({busy, halted, imem_req, decode_enable, alu_start, reg_write_enable}), 64'h0);
    exp_evt(EV_FETCH, t0 + 1, 16'h0);
    exp_evt(EV_DEC,   t0 + 2, 16'h0);
    exp_evt(EV_ALU,   t0 + 3, 16'h0);
    exp_evt(EV_WB,    t0 + 5, 16'h0);
    run = 1'b1;
    repeat (2) tick();
    run = 1'b0;
    repeat (6) tick();
    chk("t1_pc", 64'(pc), 64'h1);
    chk("t1_busy", 64'(busy), 64'h0);
    chk("t1_instr", 64'(instruction), 64'h1000_0000);

    // JUMP to 0x40 followed by HALT there.
    mem[0] = 32'hE000_0040; mem[8'h40] = 32'hF000_0000;
    do_reset();
    exp_evt(EV_FETCH, t0 + 1, 16'h0);
    exp_evt(EV_DEC,   t0 + 2, 16'h0);
    exp_evt(EV_FETCH, t0 + 4, 16'h40);
    exp_evt(EV_DEC,   t0 + 5, 16'h0);
    run = 1'b1;
    repeat (10) tick();
    chk("t2_halted", 64'({halted, busy}), 64'h2);
    chk("t2_pc", 64'(pc), 64'h40);
    run = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t2_clear_pc", 64'(pc), 64'h0);
    chk("t2_clear_state", 64'({halted, busy}), 64'h0);

    // Three ALU ops with slow memory and ALU, HALT at address 3.
    mem[0] = 32'h1000_0000; mem[1] = 32'h2000_0000; mem[2] = 32'h3000_0000;
    mem[3] = 32'hF000_0000;
    imem_lat = 1; alu_lat = 2;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_evt(EV_FETCH, t0 + 1 + 7*k, 16'(k));
      exp_evt(EV_DEC,   t0 + 3 + 7*k, 16'h0);
      exp_evt(EV_ALU,   t0 + 4 + 7*k, 16'h0);
      exp_evt(EV_WB,    t0 + 7 + 7*k, 16'(k));
    end
    exp_evt(EV_FETCH, t0 + 22, 16'h3);
    exp_evt(EV_DEC,   t0 + 24, 16'h0);
    run = 1'b1; clear = 1'b1;
    repeat (10) tick();
    clear = 1'b0;
    repeat (26) tick();
    chk("t3_halted", 64'({halted, busy, imem_req}), 64'h4);
    chk("t3_pc", 64'(pc), 64'h3);
    run = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_clear_pc", 64'(pc), 64'h0);
    chk("t3_clear_state", 64'({halted, busy}), 64'h0);

    // PC wrap: jump to 0xFF, ALU op there, pc returns to 0.
    mem[0] = 32'hE000_00FF; mem[8'hFF] = 32'h1000_0000;
    imem_lat = 0; alu_lat = 1;
    do_reset();
    exp_evt(EV_FETCH, t0 + 1, 16'h0);
    exp_evt(EV_DEC,   t0 + 2, 16'h0);
    exp_evt(EV_FETCH, t0 + 4, 16'hFF);
    exp_evt(EV_DEC,   t0 + 5, 16'h0);
    exp_evt(EV_ALU,   t0 + 6, 16'h0);
    exp_evt(EV_WB,    t0 + 8, 16'hFF);
    run = 1'b1;
    repeat (4) tick();
    run = 1'b0;
    repeat (6) tick();
    chk("t4_pc_wrap", 64'(pc), 64'h0);
    chk("t4_busy", 64'(busy), 64'h0);

    // Reset during ALU_WAIT; the late alu_done must be ignored.
    mem[0] = 32'h1000_0000;
    alu_lat = 2;
    do_reset();
    exp_evt(EV_FETCH, t0 + 1, 16'h0);
    exp_evt(EV_DEC,   t0 + 2, 16'h0);
    exp_evt(EV_ALU,   t0 + 3, 16'h0);
    run = 1'b1;
    repeat (2) tick();
    run = 1'b0;
    repeat (2) tick();
    chk("t5_busy_wait", 64'(busy), 64'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_alu_done_late", 64'(alu_done), 64'h1);
    chk("t5_rst_state", 64'({busy, halted, pc}), 64'h0);
    chk("t5_rst_instr", 64'(instruction), 64'h0);
    repeat (4) tick();
    chk("t5_idle", 64'({busy, reg_write_enable, pc}), 64'h0);

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    // Single step with run low executes exactly one instruction.
    mem[0] = 32'h1000_0000; mem[1] = 32'h1000_0000;
    alu_lat = 1;
    do_reset();
    exp_evt(EV_FETCH, t0 + 1, 16'h0);
    exp_evt(EV_DEC,   t0 + 2, 16'h0);
    exp_evt(EV_ALU,   t0 + 3, 16'h0);
    exp_evt(EV_WB,    t0 + 5, 16'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (10) tick();
    chk("t6_step_pc", 64'(pc), 64'h1);
    chk("t6_step_idle", 64'({busy, imem_req}), 64'h0);
`endif

    chk("sb_empty", 64'(sbq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
